// File: rtl/depth_colour_mapper_pkg.sv
// Shared types and defaults for the depth-to-colour stage.
package colour_pkg;

  localparam int unsigned DEPTH_W   = 8;
  localparam int unsigned GRAY_GAIN = 10;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t RGB_BLACK = '0;

  // Per-pixel state captured at input accept; colour is resolved one stage later.
  typedef struct packed {
    logic       sof;
    logic       eol;
    logic       in_set;
    logic       pal_en;
    logic [7:0] grey;
  } s1_t;

endpackage

// File: rtl/depth_colour_mapper_if.sv
// Pixel stream, palette write port and control inputs of the colour mapper.
interface depth_colour_mapper_if #(
  parameter int unsigned DEPTH_W = colour_pkg::DEPTH_W
);
  logic [DEPTH_W-1:0] in_depth;
  logic               in_sof;
  logic               in_eol;
  logic               in_valid;
  logic               in_ready;
  logic [DEPTH_W-1:0] max_iter;
  logic               pal_en;
  logic               pal_we;
  logic [DEPTH_W-1:0] pal_waddr;
  logic [23:0]        pal_wdata;
  logic [7:0]         out_r;
  logic [7:0]         out_g;
  logic [7:0]         out_b;
  logic               out_sof;
  logic               out_eol;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output in_depth, in_sof, in_eol, in_valid, max_iter, pal_en,
           pal_we, pal_waddr, pal_wdata, out_ready,
    input  in_ready, out_r, out_g, out_b, out_sof, out_eol, out_valid
  );

  modport slave (
    input  in_depth, in_sof, in_eol, in_valid, max_iter, pal_en,
           pal_we, pal_waddr, pal_wdata, out_ready,
    output in_ready, out_r, out_g, out_b, out_sof, out_eol, out_valid
  );
endinterface

// File: rtl/depth_colour_mapper_palette_ram.sv
// Simple dual-port palette RAM, read-first on same-address collision.
module palette_ram #(
  parameter int unsigned DEPTH_W     = 8,
  parameter int unsigned PAL_ENTRIES = 256
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [DEPTH_W-1:0] waddr_i,
  input  logic [23:0]        wdata_i,
  input  logic               re_i,
  input  logic [DEPTH_W-1:0] raddr_i,
  output logic [23:0]        rdata_o
);

  logic [23:0] mem_q [PAL_ENTRIES];

  // No reset so the array maps onto RAM primitives and survives reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/depth_colour_mapper.sv
// Two-stage depth-to-RGB mapper: greyscale ramp or palette lookup, valid/ready on both sides.
module depth_colour_mapper
  import colour_pkg::*;
#(
  parameter int unsigned DEPTH_W     = colour_pkg::DEPTH_W,
  parameter int unsigned GRAY_GAIN   = colour_pkg::GRAY_GAIN,
  parameter int unsigned PAL_ENTRIES = 2 ** DEPTH_W
) (
  input  logic                  out_stream_aclk,
  input  logic                  reset,
  depth_colour_mapper_if.slave  bus
);

  logic               v1_q, v1_d;
  logic               v2_q, v2_d;
  s1_t                s1_q, s1_d;
  rgb_t               col_q, col_d;
  logic               sof2_q, sof2_d;
  logic               eol2_q, eol2_d;
  logic               s1_load, s2_load, accept;
  logic [DEPTH_W+3:0] grey_full;
  logic [7:0]         grey_sat;
  logic [23:0]        pal_rdata;

  assign s2_load = !v2_q || bus.out_ready;
  assign s1_load = !v1_q || s2_load;
  assign accept  = bus.in_valid && s1_load;

  assign grey_full = (DEPTH_W + 4)'(bus.in_depth) * (DEPTH_W + 4)'(GRAY_GAIN);
  assign grey_sat  = (|grey_full[DEPTH_W+3:8]) ? 8'hFF : grey_full[7:0];

  // Read enable tied to accept keeps the read data parked with S1 while stalled.
  palette_ram #(
    .DEPTH_W     (DEPTH_W),
    .PAL_ENTRIES (PAL_ENTRIES)
  ) u_palette (
    .clk_i   (out_stream_aclk),
    .we_i    (bus.pal_we),
    .waddr_i (bus.pal_waddr),
    .wdata_i (bus.pal_wdata),
    .re_i    (accept),
    .raddr_i (bus.in_depth),
    .rdata_o (pal_rdata)
  );

  always_comb begin
    v1_d = v1_q;
    s1_d = s1_q;
    if (s1_load) begin
      v1_d = bus.in_valid;
      if (accept) begin
        s1_d.sof    = bus.in_sof;
        s1_d.eol    = bus.in_eol;
        s1_d.in_set = (bus.in_depth == bus.max_iter);
        s1_d.pal_en = bus.pal_en;
        s1_d.grey   = grey_sat;
      end
    end
  end

  always_comb begin
    v2_d   = v2_q;
    col_d  = col_q;
    sof2_d = sof2_q;
    eol2_d = eol2_q;
    if (s2_load) begin
      v2_d = v1_q;
      if (v1_q) begin
        if (s1_q.in_set)      col_d = RGB_BLACK;
        else if (s1_q.pal_en) col_d = rgb_t'(pal_rdata);
        else                  col_d = '{r: s1_q.grey, g: s1_q.grey, b: s1_q.grey};
        sof2_d = s1_q.sof;
        eol2_d = s1_q.eol;
      end
    end
  end

  always_ff @(posedge out_stream_aclk or posedge reset) begin
    if (reset) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      s1_q   <= '0;
      col_q  <= RGB_BLACK;
      sof2_q <= 1'b0;
      eol2_q <= 1'b0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      s1_q   <= s1_d;
      col_q  <= col_d;
      sof2_q <= sof2_d;
      eol2_q <= eol2_d;
    end
  end

  assign bus.in_ready  = s1_load;
  assign bus.out_valid = v2_q;
  assign bus.out_r     = col_q.r;
  assign bus.out_g     = col_q.g;
  assign bus.out_b     = col_q.b;
  assign bus.out_sof   = sof2_q;
  assign bus.out_eol   = eol2_q;

endmodule
